// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, three MSB-first bytes each followed by an ACK slot, STOP.
// SCL is push-pull; SDA is open-drain and released on reset or idle.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] i2c_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ack,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_e;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [9:0]  div_q, div_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        busy_q;
  logic        scl_q, scl_d;
  logic        sda_low_q, sda_low_d;
  logic        qtick;

  assign qtick = (state_q != ST_IDLE) && (div_q == DIV_LAST);

  // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    quarter_d  = quarter_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    ack_d      = ack_q;

    if (state_q == ST_IDLE) begin
      div_d     = '0;
      quarter_d = '0;
      // The done cycle is still IDLE; refusing start there separates back-to-back transfers.
      if (start && !done_q) begin
        state_d    = ST_START;
        shift_d    = i2c_data;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        nack_d     = 1'b0;
      end
    end else begin
      div_d = qtick ? '0 : div_q + 10'd1;
      if (qtick) begin
        quarter_d = quarter_q + 2'd1;
        // The slave's answer is taken at the very end of q2, mid SCL-high.
        if (state_q == ST_ACK && quarter_q == 2'd2) begin
          nack_d = nack_q | i2c_sdat;
        end
        if (quarter_q == 2'd3) begin
          case (state_q)
            ST_START: state_d = ST_BIT;
            ST_BIT: begin
              shift_d   = {shift_q[22:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = ST_ACK;
            end
            ST_ACK: begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = (nack_q || byte_cnt_q == 2'd2) ? ST_STOP : ST_BIT;
            end
            ST_STOP: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              ack_d   = ~nack_q;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  // Bus levels are decoded from next-state values and registered, so they are glitch-free
  // yet line up with the step and quarter they belong to.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      ST_START: sda_low_d = quarter_d[1];
      ST_BIT: begin
        scl_d     = quarter_d[1];
        sda_low_d = ~shift_d[23];
      end
      ST_ACK:   scl_d = quarter_d[1];
      ST_STOP: begin
        scl_d     = quarter_d[1];
        sda_low_d = (quarter_d != 2'd3);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      quarter_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      quarter_q  <= quarter_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      busy_q     <= (state_d != ST_IDLE);
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ack      = ack_q;
  assign i2c_sclk = scl_q;
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master at CLK_DIV=4 with a bus-level slave model
// that ACKs every byte except the one selected by nack_byte.
module tb_i2c_write_master;

  localparam int CLK_DIV = 4;
  localparam int FULL_LAT = 116 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] i2c_data = '0;
  logic        start = 1'b0;
  logic        busy, done, ack, scl;
  wire         sda_w;
  logic        slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .i2c_data (i2c_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ack      (ack),
    .i2c_sclk (scl),
    .i2c_sdat (sda_w)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Bus monitor and slave model, all sampled on the falling clk edge.
  int          cyc = 0;
  int          start_cnt = 0, stop_cnt = 0, done_cnt = 0, width_err = 0, conflict_cnt = 0;
  int          busy_edges[$];
  int          done_edges[$];
  logic [7:0]  rx_q[$];
  int          nack_byte = 0;
  int          bit_cnt = 0, byte_idx = 0;
  bit          in_ack = 1'b0;
  logic [7:0]  rx_sh = '0;
  logic        scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0, done_prev = 1'b0;
  logic        ack_at_done = 1'b0, busy_at_done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      slave_low = 1'b0;
      in_ack    = 1'b0;
      bit_cnt   = 0;
      byte_idx  = 0;
    end else begin
      if (slave_low && sda_w !== 1'b0) conflict_cnt++;
      if (scl && scl_prev && sda_w !== sda_prev) begin
        if (sda_w === 1'b0) begin
          start_cnt++;
          bit_cnt  = 0;
          in_ack   = 1'b0;
          byte_idx = 0;
        end else begin
          stop_cnt++;
        end
      end
      if (scl && !scl_prev && !in_ack) begin
        rx_sh = {rx_sh[6:0], sda_w};
        bit_cnt++;
        if (bit_cnt == 8) rx_q.push_back(rx_sh);
      end
      if (!scl && scl_prev) begin
        if (in_ack) begin
          slave_low = 1'b0;
          in_ack    = 1'b0;
          bit_cnt   = 0;
          byte_idx++;
        end else if (bit_cnt == 8) begin
          in_ack    = 1'b1;
          slave_low = (byte_idx + 1 != nack_byte);
        end
      end
      if (busy && !busy_prev) busy_edges.push_back(cyc);
      if (done) begin
        done_edges.push_back(cyc);
        done_cnt++;
        if (done_prev) width_err++;
        ack_at_done  = ack;
        busy_at_done = busy;
      end
    end
    scl_prev  = scl;
    sda_prev  = sda_w;
    busy_prev = busy;
    done_prev = done;
  end

  task automatic clear_mon();
    start_cnt = 0;
    stop_cnt  = 0;
    done_cnt  = 0;
    width_err = 0;
    rx_q.delete();
    busy_edges.delete();
    done_edges.delete();
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < n) check("done_timeout", done_cnt, n);
  endtask

  task automatic run_xfer(input logic [23:0] data, input int nk, input int exp_lat,
                          input logic exp_ack, input int exp_bytes);
    int          s_edge;
    logic [23:0] sh;
    clear_mon();
    nack_byte = nk;
    @(negedge clk);
    i2c_data = data;
    start    = 1'b1;
    s_edge   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    wait_done(1, 2000);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("done_width", width_err, 0);
    check("latency", (done_edges.size() > 0) ? done_edges[0] - s_edge : -1, exp_lat);
    check("busy_next_cycle", (busy_edges.size() > 0) ? busy_edges[0] : -1, s_edge);
    check("ack", ack_at_done, exp_ack);
    check("busy_at_done", busy_at_done, 0);
    check("bytes_seen", rx_q.size(), exp_bytes);
    sh = data;
    for (int i = 0; i < exp_bytes; i++) begin
      if (i < rx_q.size()) check("byte_value", rx_q[i], sh[23:16]);
      sh = sh << 8;
    end
    check("start_conds", start_cnt, 1);
    check("stop_conds", stop_cnt, 1);
    check("idle_scl", scl, 1);
    check("idle_sda", sda_w, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_edge;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_w, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack", ack, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);

    // Full transfers, then NACK on each byte position.
    run_xfer(24'h340C10, 0, FULL_LAT, 1'b1, 3);
    run_xfer(24'hA5F00F, 1, (8 + 36 * 1) * CLK_DIV, 1'b0, 1);
    run_xfer(24'h80FF01, 2, (8 + 36 * 2) * CLK_DIV, 1'b0, 2);
    run_xfer(24'h007E81, 3, (8 + 36 * 3) * CLK_DIV, 1'b0, 3);
    run_xfer(24'hFF00AA, 0, FULL_LAT, 1'b1, 3);

    // Start held high: two back-to-back transfers.
    clear_mon();
    nack_byte = 0;
    @(negedge clk);
    i2c_data = 24'h123456;
    start    = 1'b1;
    s_edge   = cyc + 1;
    repeat (600) @(negedge clk);
    start = 1'b0;
    wait_done(2, 1500);
    @(negedge clk);
    check("hold_dones", done_cnt, 2);
    if (busy_edges.size() >= 2 && done_edges.size() >= 2) begin
      check("hold_lat1", done_edges[0] - s_edge, FULL_LAT);
      check("hold_gap", busy_edges[1] - done_edges[0], 2);
      check("hold_lat2", done_edges[1] - busy_edges[1], FULL_LAT);
    end
    check("hold_width", width_err, 0);
    check("hold_bytes", rx_q.size(), 6);
    check("hold_starts", start_cnt, 2);
    check("hold_stops", stop_cnt, 2);
    repeat (50) @(negedge clk);
    check("hold_quiet", busy, 0);

    // Second start pulse during busy is ignored.
    clear_mon();
    @(negedge clk);
    i2c_data = 24'hC35A96;
    start    = 1'b1;
    s_edge   = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    i2c_data = 24'hFFFFFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 2000);
    repeat (520) @(negedge clk);
    check("ign_dones", done_cnt, 1);
    check("ign_busy_rises", busy_edges.size(), 1);
    check("ign_lat", (done_edges.size() > 0) ? done_edges[0] - s_edge : -1, FULL_LAT);
    check("ign_bytes", rx_q.size(), 3);
    if (rx_q.size() == 3) check("ign_byte1", rx_q[1], 8'h5A);
    check("ign_ack", ack, 1);

    // Asynchronous reset in the middle of byte 2.
    clear_mon();
    begin
      int k = 0;
      @(negedge clk);
      i2c_data = 24'h3C96E7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (rx_q.size() < 1 && k < 1000) begin
        @(negedge clk);
        k++;
      end
      check("mid_byte1_seen", rx_q.size(), 1);
    end
    repeat (60) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda_w, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_xfer(24'h5AFF00, 0, FULL_LAT, 1'b1, 3);

    check("sda_conflicts", conflict_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
